ship_lives_ctl: RTL and testbench
=================================

Name: ship_lives_ctl

Overview:
Downstream consumer of the ship collision detector's registered is_ship_dead flag.
Turns a hit into game-level consequences:
- decrements the lives counter;
- runs a frame-timed explosion phase;
- runs a blinking invulnerable respawn phase;
- latches game over when lives reach zero.

Its outputs drive the ship sprite renderer, the ship movement/fire logic, the explosion sprite and the HUD.

Parameters:
START_LIVES, 3, lives loaded on game_start (1..7).
LIVES_W, 3, width of lives output.
EXPLODE_FRAMES, 32, frames in explosion phase; power of two, >= 8.
INVULN_FRAMES, 128, frames in invulnerable respawn phase; power of two.
BLINK_PERIOD, 8, frames per visible/hidden half-cycle of the respawn blink; power of two.

Ports:
pclk  input  1  peripheral clock, the single clock domain.
rst  input  1  synchronous reset, active-high.
frame_tick  input  1  one-cycle pulse per video frame (start of vblank).
game_start  input  1  one-cycle start request from menu logic.
is_ship_dead  input  1  registered hit flag from the collision detector; may stay high for several cycles.
lives  output  LIVES_W  remaining lives.
ship_visible  output  1  ship sprite draw enable.
ship_ctrl_en  output  1  movement/fire enable for the ship.
explode_active  output  1  explosion sprite enable.
explode_frame  output  3  explosion animation frame index, 0..7.
hit_pulse  output  1  one-cycle pulse per accepted hit (sound/score hook).
game_over  output  1  high while in GAME_OVER.

Behaviour:
- All outputs are registered. Reset values: state IDLE, lives=START_LIVES, frame counter 0, ship_visible=0, ship_ctrl_en=0, explode_active=0, explode_frame=0, hit_pulse=0, game_over=0.
- Reset asserted mid-operation returns to these values on the next edge. No partial state survives.
- States: IDLE, ALIVE, EXPLODE, INVULN, GAME_OVER.
- IDLE:
  - game_start -> ALIVE, lives=START_LIVES, counter cleared.
  - is_ship_dead is ignored.
- ALIVE: ship_visible=1, ship_ctrl_en=1.
  - is_ship_dead=1 in cycle N -> at N+1: state EXPLODE, lives=lives-1, hit_pulse=1 for that one cycle, counter=0, ship_visible=0, ship_ctrl_en=0, explode_active=1.
  - A multi-cycle is_ship_dead level produces exactly one hit, because the state leaves ALIVE.
- EXPLODE:
  - The counter increments on each frame_tick.
  - explode_frame = counter / (EXPLODE_FRAMES/8).
  - When frame_tick arrives with counter == EXPLODE_FRAMES-1: go to INVULN if lives != 0, else GAME_OVER. Counter clears on exit.
  - is_ship_dead is ignored.
- INVULN: ship_ctrl_en=1.
  - ship_visible=1 when (counter / BLINK_PERIOD) is even, else 0.
  - is_ship_dead is ignored.
  - When frame_tick arrives with counter == INVULN_FRAMES-1: go to ALIVE, ship_visible=1.
- GAME_OVER: game_over=1, ship_visible=0, ship_ctrl_en=0, explode_active=0. lives holds 0.
  - game_start -> ALIVE with lives=START_LIVES, game_over=0.
- Simultaneous events:
  - is_ship_dead and frame_tick in the same ALIVE cycle: the hit wins and the counter starts at 0; that tick is not counted.
  - game_start is ignored in ALIVE, EXPLODE and INVULN.
- lives decrement saturates at 0 and never wraps.
- The counter is wide enough for max(EXPLODE_FRAMES, INVULN_FRAMES)-1, with no wrap inside a phase.
- Cycles without frame_tick leave the counter unchanged.

Decomposition:
- Shared game package holds:
  - state encodings (IDLE, ALIVE, EXPLODE, INVULN, GAME_OVER);
  - SHIP_ALIVE / SHIP_SHOOT_DOWN flag constants, shared with the collision detector;
  - default START_LIVES, EXPLODE_FRAMES, INVULN_FRAMES, BLINK_PERIOD.
- One natural sub-module: frame_timer.
  - Inputs: clear, tick.
  - Outputs: count, done (count == limit-1 and tick).
  - It is instantiated once and reused across EXPLODE and INVULN with a muxed limit.

Test Plan:
- Reset, then game_start -> next cycle ALIVE, lives=3, ship_visible=1, ship_ctrl_en=1, game_over=0.
- In ALIVE, hold is_ship_dead high for 5 cycles -> exactly one hit_pulse, lives=2, explode_active=1. After 32 frame_ticks, INVULN with explode_frame having stepped 0..7, 4 ticks each.
- In INVULN, pulse is_ship_dead at frame 10 -> ignored, lives stays 2. ship_visible pattern: 1 for frames 0-7, 0 for 8-15, and so on. After 128 ticks, ALIVE with ship_visible=1.
- Three hits in sequence -> after the third explosion: GAME_OVER, lives=0, game_over=1, ship_visible=0. game_start then gives ALIVE with lives=3.
- is_ship_dead and frame_tick asserted in the same ALIVE cycle -> EXPLODE with counter=0. The explosion still lasts exactly 32 further frame_ticks.
- Assert rst during EXPLODE at counter=17 -> next cycle all outputs at reset values, state IDLE. game_start then starts a fresh game with lives=3.

Source files
------------

// File: rtl/ship_lives_ctl_pkg.sv
// ship_lives_ctl_pkg: shared game state encodings, ship flags and default timing constants
package ship_lives_ctl_pkg;
   typedef enum logic [2:0] {IDLE, ALIVE, EXPLODE, INVULN, GAME_OVER} state_t;
   localparam logic SHIP_ALIVE = 1'b0;
   localparam logic SHIP_SHOOT_DOWN = 1'b1;
   localparam int DEF_START_LIVES = 3;
   localparam int DEF_EXPLODE_FRAMES = 32;
   localparam int DEF_INVULN_FRAMES = 128;
   localparam int DEF_BLINK_PERIOD = 8;
endpackage

// File: rtl/ship_lives_ctl_if.sv
// ship_lives_ctl_if: hit/frame inputs and sprite/HUD outputs of the lives controller
interface ship_lives_ctl_if #(parameter int LIVES_W = 3);
   logic frame_tick;
   logic game_start;
   logic is_ship_dead;
   logic [LIVES_W-1:0] lives;
   logic ship_visible;
   logic ship_ctrl_en;
   logic explode_active;
   logic [2:0] explode_frame;
   logic hit_pulse;
   logic game_over;
   modport master(output frame_tick, game_start, is_ship_dead,
                  input lives, ship_visible, ship_ctrl_en, explode_active, explode_frame, hit_pulse, game_over);
   modport slave(input frame_tick, game_start, is_ship_dead,
                 output lives, ship_visible, ship_ctrl_en, explode_active, explode_frame, hit_pulse, game_over);
endinterface

// File: rtl/ship_lives_ctl_frame_timer.sv
// frame_timer: frame-tick counter with clear and a done strobe on the last frame of a phase
module frame_timer #(
   parameter int CW = 7
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          clear,
   input  logic          tick,
   input  logic [CW:0]   limit,
   output logic [CW-1:0] count,
   output logic          done
);
   assign done = tick && ({1'b0, count} == limit - 1'b1);
   always_ff @(posedge pclk)
      if (rst || clear) count <= '0;
      else if (tick) count <= count + 1'b1;
endmodule

// File: rtl/ship_lives_ctl.sv
// ship_lives_ctl: turns collision hits into lives, explosion, blinking respawn and game over
module ship_lives_ctl
   import ship_lives_ctl_pkg::*;
#(
   parameter int START_LIVES    = DEF_START_LIVES,
   parameter int LIVES_W        = 3,
   parameter int EXPLODE_FRAMES = DEF_EXPLODE_FRAMES,
   parameter int INVULN_FRAMES  = DEF_INVULN_FRAMES,
   parameter int BLINK_PERIOD   = DEF_BLINK_PERIOD
) (
   input logic pclk,
   input logic rst,
   ship_lives_ctl_if.slave bus
);
   localparam int MAXF = EXPLODE_FRAMES > INVULN_FRAMES ? EXPLODE_FRAMES : INVULN_FRAMES;
   localparam int CW = $clog2(MAXF);
   localparam int ES = $clog2(EXPLODE_FRAMES / 8);
   localparam int BB = $clog2(BLINK_PERIOD);
   localparam logic [LIVES_W-1:0] START = LIVES_W'(START_LIVES);
   state_t state;
   logic clear, done;
   logic [CW-1:0] count, adv;
   logic [CW:0] limit;
   assign limit = (state == EXPLODE) ? (CW+1)'(EXPLODE_FRAMES) : (CW+1)'(INVULN_FRAMES);
   assign clear = !(state inside {EXPLODE, INVULN}) || done;
   // value the counter takes at this edge, so outputs stay registered yet in step with it
   assign adv = done ? '0 : bus.frame_tick ? count + 1'b1 : count;
   frame_timer #(.CW(CW)) timer (
      .pclk(pclk), .rst(rst), .clear(clear), .tick(bus.frame_tick), .limit(limit),
      .count(count), .done(done)
   );
   always_ff @(posedge pclk) begin
      if (rst) begin
         state <= IDLE;
         bus.lives <= START;
         bus.ship_visible <= 1'b0;
         bus.ship_ctrl_en <= 1'b0;
         bus.explode_active <= 1'b0;
         bus.explode_frame <= '0;
         bus.hit_pulse <= 1'b0;
         bus.game_over <= 1'b0;
      end else begin
         bus.hit_pulse <= 1'b0;
         case (state)
            IDLE, GAME_OVER:
               if (bus.game_start) begin
                  state <= ALIVE;
                  bus.lives <= START;
                  bus.ship_visible <= 1'b1;
                  bus.ship_ctrl_en <= 1'b1;
                  bus.game_over <= 1'b0;
               end
            ALIVE:
               if (bus.is_ship_dead == SHIP_SHOOT_DOWN) begin
                  state <= EXPLODE;
                  bus.lives <= (bus.lives == '0) ? '0 : bus.lives - 1'b1;
                  bus.hit_pulse <= 1'b1;
                  bus.ship_visible <= 1'b0;
                  bus.ship_ctrl_en <= 1'b0;
                  bus.explode_active <= 1'b1;
                  bus.explode_frame <= '0;
               end
            EXPLODE: begin
               bus.explode_frame <= 3'(adv >> ES);
               if (done) begin
                  state <= (bus.lives != '0) ? INVULN : GAME_OVER;
                  bus.explode_active <= 1'b0;
                  bus.ship_visible <= bus.lives != '0;
                  bus.ship_ctrl_en <= bus.lives != '0;
                  bus.game_over <= bus.lives == '0;
               end
            end
            INVULN: begin
               bus.ship_visible <= !adv[BB];
               if (done) state <= ALIVE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ship_lives_ctl.sv
// tb_ship_lives_ctl: directed scenario tests for the ship lives controller
module tb_ship_lives_ctl;
   logic pclk = 1'b0;
   logic rst = 1'b0;
   int tests = 0;
   int fails = 0;
   ship_lives_ctl_if #(.LIVES_W(3)) bus ();
   ship_lives_ctl dut (.pclk(pclk), .rst(rst), .bus(bus.slave));
   always #5 pclk = ~pclk;

   // {lives, visible, ctrl_en, explode_active, explode_frame, hit_pulse, game_over}
   function automatic logic [10:0] obs();
      return {bus.lives, bus.ship_visible, bus.ship_ctrl_en, bus.explode_active,
              bus.explode_frame, bus.hit_pulse, bus.game_over};
   endfunction

   function automatic logic [10:0] ex(int l, bit v, bit c, bit x, int f, bit h, bit g);
      return {3'(l), v, c, x, 3'(f), h, g};
   endfunction

   task automatic step(input bit ft, input bit gs, input bit dead);
      bus.frame_tick = ft;
      bus.game_start = gs;
      bus.is_ship_dead = dead;
      @(posedge pclk);
      #1;
      bus.frame_tick = 1'b0;
      bus.game_start = 1'b0;
      bus.is_ship_dead = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tests++;
      if (obs() !== ex(3, 0, 0, 0, 0, 0, 0)) begin
         $display("FAIL reset: got %b expected %b", obs(), ex(3, 0, 0, 0, 0, 0, 0));
         fails++;
      end
      step(1'b1, 1'b0, 1'b1);
      tests++;
      if (obs() !== ex(3, 0, 0, 0, 0, 0, 0)) begin
         $display("FAIL idle_ignores_hit: got %b expected %b", obs(), ex(3, 0, 0, 0, 0, 0, 0));
         fails++;
      end
      step(1'b0, 1'b1, 1'b0);
      tests++;
      if (obs() !== ex(3, 1, 1, 0, 0, 0, 0)) begin
         $display("FAIL start: got %b expected %b", obs(), ex(3, 1, 1, 0, 0, 0, 0));
         fails++;
      end
   endtask

   task automatic test_hit_hold();
      int hits = 0;
      step(1'b0, 1'b0, 1'b1);
      hits += int'(bus.hit_pulse);
      tests++;
      if (obs() !== ex(2, 0, 0, 1, 0, 1, 0)) begin
         $display("FAIL hit_entry: got %b expected %b", obs(), ex(2, 0, 0, 1, 0, 1, 0));
         fails++;
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1);
         hits += int'(bus.hit_pulse);
      end
      step(1'b0, 1'b0, 1'b0);
      hits += int'(bus.hit_pulse);
      tests++;
      if (hits !== 1 || bus.lives !== 3'd2) begin
         $display("FAIL hit_hold: got hits=%0d lives=%0d expected hits=1 lives=2", hits, bus.lives);
         fails++;
      end
      for (int i = 0; i < 31; i++) begin
         step(1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
         tests++;
         if (obs() !== ex(2, 0, 0, 1, (i + 1) / 4, 0, 0)) begin
            $display("FAIL explode_frame[%0d]: got %b expected %b", i + 1, obs(), ex(2, 0, 0, 1, (i + 1) / 4, 0, 0));
            fails++;
         end
      end
      step(1'b1, 1'b0, 1'b0);
      tests++;
      if (obs() !== ex(2, 1, 1, 0, 0, 0, 0)) begin
         $display("FAIL explode_exit: got %b expected %b", obs(), ex(2, 1, 1, 0, 0, 0, 0));
         fails++;
      end
   endtask

   task automatic test_invuln();
      for (int i = 0; i < 128; i++) begin
         tests++;
         if (obs() !== ex(2, ((i / 8) % 2) == 0, 1, 0, 0, 0, 0)) begin
            $display("FAIL blink[%0d]: got %b expected %b", i, obs(), ex(2, ((i / 8) % 2) == 0, 1, 0, 0, 0, 0));
            fails++;
         end
         if (i == 10) begin
            step(1'b0, 1'b1, 1'b1);
            tests++;
            if (obs() !== ex(2, 0, 1, 0, 0, 0, 0)) begin
               $display("FAIL invuln_ignores_hit: got %b expected %b", obs(), ex(2, 0, 1, 0, 0, 0, 0));
               fails++;
            end
         end
         step(1'b1, 1'b0, 1'b0);
      end
      tests++;
      if (obs() !== ex(2, 1, 1, 0, 0, 0, 0)) begin
         $display("FAIL invuln_exit: got %b expected %b", obs(), ex(2, 1, 1, 0, 0, 0, 0));
         fails++;
      end
      step(1'b0, 1'b0, 1'b1);
      tests++;
      if (obs() !== ex(1, 0, 0, 1, 0, 1, 0)) begin
         $display("FAIL alive_after_invuln: got %b expected %b", obs(), ex(1, 0, 0, 1, 0, 1, 0));
         fails++;
      end
   endtask

   task automatic test_game_over();
      ticks(32);
      ticks(128);
      step(1'b0, 1'b0, 1'b1);
      tests++;
      if (obs() !== ex(0, 0, 0, 1, 0, 1, 0)) begin
         $display("FAIL last_hit: got %b expected %b", obs(), ex(0, 0, 0, 1, 0, 1, 0));
         fails++;
      end
      ticks(10);
      step(1'b0, 1'b1, 1'b1);
      tests++;
      if (obs() !== ex(0, 0, 0, 1, 2, 0, 0)) begin
         $display("FAIL explode_ignores_start: got %b expected %b", obs(), ex(0, 0, 0, 1, 2, 0, 0));
         fails++;
      end
      ticks(22);
      tests++;
      if (obs() !== ex(0, 0, 0, 0, 0, 0, 1)) begin
         $display("FAIL game_over: got %b expected %b", obs(), ex(0, 0, 0, 0, 0, 0, 1));
         fails++;
      end
      step(1'b1, 1'b0, 1'b1);
      tests++;
      if (obs() !== ex(0, 0, 0, 0, 0, 0, 1)) begin
         $display("FAIL game_over_hold: got %b expected %b", obs(), ex(0, 0, 0, 0, 0, 0, 1));
         fails++;
      end
      step(1'b0, 1'b1, 1'b0);
      tests++;
      if (obs() !== ex(3, 1, 1, 0, 0, 0, 0)) begin
         $display("FAIL restart: got %b expected %b", obs(), ex(3, 1, 1, 0, 0, 0, 0));
         fails++;
      end
   endtask

   task automatic test_simultaneous();
      step(1'b1, 1'b0, 1'b1);
      tests++;
      if (obs() !== ex(2, 0, 0, 1, 0, 1, 0)) begin
         $display("FAIL simul_hit: got %b expected %b", obs(), ex(2, 0, 0, 1, 0, 1, 0));
         fails++;
      end
      ticks(31);
      tests++;
      if (obs() !== ex(2, 0, 0, 1, 7, 0, 0)) begin
         $display("FAIL simul_31: got %b expected %b", obs(), ex(2, 0, 0, 1, 7, 0, 0));
         fails++;
      end
      step(1'b1, 1'b0, 1'b0);
      tests++;
      if (obs() !== ex(2, 1, 1, 0, 0, 0, 0)) begin
         $display("FAIL simul_32: got %b expected %b", obs(), ex(2, 1, 1, 0, 0, 0, 0));
         fails++;
      end
   endtask

   task automatic test_reset_mid();
      ticks(128);
      step(1'b0, 1'b0, 1'b1);
      ticks(17);
      tests++;
      if (obs() !== ex(1, 0, 0, 1, 4, 0, 0)) begin
         $display("FAIL before_rst: got %b expected %b", obs(), ex(1, 0, 0, 1, 4, 0, 0));
         fails++;
      end
      rst = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      tests++;
      if (obs() !== ex(3, 0, 0, 0, 0, 0, 0)) begin
         $display("FAIL mid_reset: got %b expected %b", obs(), ex(3, 0, 0, 0, 0, 0, 0));
         fails++;
      end
      step(1'b1, 1'b0, 1'b1);
      tests++;
      if (obs() !== ex(3, 0, 0, 0, 0, 0, 0)) begin
         $display("FAIL idle_after_rst: got %b expected %b", obs(), ex(3, 0, 0, 0, 0, 0, 0));
         fails++;
      end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      ticks(3);
      tests++;
      if (obs() !== ex(2, 0, 0, 1, 0, 0, 0)) begin
         $display("FAIL fresh_count3: got %b expected %b", obs(), ex(2, 0, 0, 1, 0, 0, 0));
         fails++;
      end
      ticks(1);
      tests++;
      if (obs() !== ex(2, 0, 0, 1, 1, 0, 0)) begin
         $display("FAIL fresh_count4: got %b expected %b", obs(), ex(2, 0, 0, 1, 1, 0, 0));
         fails++;
      end
   endtask

   initial begin
      bus.frame_tick = 1'b0;
      bus.game_start = 1'b0;
      bus.is_ship_dead = 1'b0;
      test_reset();
      test_hit_hold();
      test_invuln();
      test_game_over();
      test_simultaneous();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
